// File: rtl/arbitro_acciones_mascota.sv
// Button request arbiter for the pet: synchronizes four buttons, latches one request each,
// and issues them one at a time in round-robin order with ack wait and cooldown.
module arbitro_acciones_mascota #(
  parameter int COOLDOWN = 50,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Boton_Comida,
  input  logic       Boton_Medicina,
  input  logic       Boton_Jugar,
  input  logic       Boton_Dormir,
  input  logic       accion_ack,
  output logic       accion_valida,
  output logic [1:0] accion_id,
  output logic       ocupado,
  output logic [3:0] pendientes,
  output logic       error_timeout
);

  localparam logic [15:0] COOLDOWN_LAST = 16'(COOLDOWN - 1);
  localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_ACK,
    ST_COOLDOWN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  botones;
  logic [3:0]  sync_s1;
  logic [3:0]  sync_s2;
  logic [3:0]  sync_prev;
  logic [3:0]  rise;
  logic [1:0]  rr;
  logic [1:0]  cand;
  logic [1:0]  winner;
  logic        winner_found;
  logic [15:0] counter;
  logic [3:0]  grant_clear;
  logic        timeout_hit;
  logic        cooldown_done;

  assign botones = {Boton_Dormir, Boton_Jugar, Boton_Medicina, Boton_Comida};
  assign rise    = sync_s2 & ~sync_prev;

  // prev resets to 0, so a button held through reset still yields one rise afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1   <= '0;
      sync_s2   <= '0;
      sync_prev <= '0;
    end else begin
      sync_s1   <= botones;
      sync_s2   <= sync_s1;
      sync_prev <= sync_s2;
    end
  end

  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = rr;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (!winner_found && pendientes[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign timeout_hit   = (counter == TIMEOUT_LAST);
  assign cooldown_done = (counter == COOLDOWN_LAST);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (winner_found) begin
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (accion_ack || timeout_hit) begin
          state_next = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cooldown_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // An ack landing on the final wait cycle takes priority, so no error pulse then
  always_comb begin
    accion_valida = (state == ST_GRANT);
    ocupado       = (state != ST_IDLE);
    error_timeout = (state == ST_WAIT_ACK) && timeout_hit && !accion_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (state_next != state) begin
      counter <= '0;
    end else if ((state == ST_WAIT_ACK) || (state == ST_COOLDOWN)) begin
      counter <= counter + 16'd1;
    end
  end

  assign grant_clear = (state == ST_GRANT) ? (4'b0001 << accion_id) : 4'b0000;

  // A new rise during its own grant cycle re-arms the bit instead of being lost
  always_ff @(posedge clk) begin
    if (reset) begin
      pendientes <= '0;
    end else begin
      pendientes <= (pendientes & ~grant_clear) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accion_id <= '0;
      rr        <= '0;
    end else if ((state == ST_IDLE) && winner_found) begin
      accion_id <= winner;
      rr        <= winner + 2'd1;
    end
  end

endmodule

// File: doc/arbitro_acciones_mascota.md
# arbitro_acciones_mascota

Request arbiter and sequencer sitting between the pet's front-panel buttons and the pet state/mode machine. It synchronizes four raw buttons, latches one pending request per button, and grants them one at a time in round-robin order. Each grant is a one-cycle action strobe to the state machine, followed by an acknowledge wait and a fixed cooldown. Simultaneous or rapid presses are serialized instead of being lost or overlapping.

## Interface
Parameters:
- COOLDOWN, 50: idle cycles after each completed action before the next grant (1..65535).
- TIMEOUT, 1000: maximum cycles to wait for `accion_ack` (1..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- Boton_Comida  in  1  raw food button, asynchronous, level.
- Boton_Medicina  in  1  raw medicine button, asynchronous, level.
- Boton_Jugar  in  1  raw play button, asynchronous, level.
- Boton_Dormir  in  1  raw sleep button, asynchronous, level.
- accion_ack  in  1  state machine has consumed the current action.
- accion_valida  out  1  one-cycle strobe: action `accion_id` is issued.
- accion_id  out  2  0=comida, 1=medicina, 2=jugar, 3=dormir; held until next grant.
- ocupado  out  1  high whenever FSM is not IDLE.
- pendientes  out  4  latched requests, bit index = action id.
- error_timeout  out  1  one-cycle pulse when the ack wait times out.

## Operation
- Per button: 2-flop synchronizer (s1, s2) plus a previous-value flop; rise = s2 & ~prev.
- A rise sets `pendientes[i]`. Further rises while bit i is already set are absorbed. No queue depth beyond 1 per button.
- Round-robin pointer `rr` (2 bits, reset 0). Search order is rr, rr+1, rr+2, rr+3 (mod 4). After granting i, rr <= i+1 mod 4.
- FSM states:
  - IDLE: if any pendientes bit is set, select the winner, register `accion_id`, go to GRANT. Otherwise stay.
  - GRANT (1 cycle): `accion_valida`=1, clear `pendientes[accion_id]`, clear the counter, go to WAIT_ACK.
  - WAIT_ACK: if `accion_ack`=1, go to COOLDOWN. Else if counter == TIMEOUT-1, pulse `error_timeout` and go to COOLDOWN. Else increment the counter. The counter is cleared on exit.
  - COOLDOWN: count COOLDOWN cycles, then go to IDLE.
- `accion_ack` is ignored outside WAIT_ACK, including during the GRANT cycle.
- Counter: 16-bit, shared by WAIT_ACK and COOLDOWN, zeroed on every state change.

## Timing
- Reset values: state IDLE, rr=0, sync/prev flops 0, pendientes=0, accion_valida=0, accion_id=0, ocupado=0, error_timeout=0, counter=0.
- Press latency: the button is high before edge E0. s1 is set at E0 and s2 at E1. `pendientes[i]` is set at E2. IDLE→GRANT occurs at E3, so `accion_valida` is high for the cycle between E3 and E4.
- Ack sampled at edge Ek in WAIT_ACK: COOLDOWN starts at Ek. The next grant's `accion_valida` is at the earliest COOLDOWN+1 cycles after Ek.
- Timeout: with no ack, the state leaves WAIT_ACK exactly TIMEOUT cycles after entry. `error_timeout` is high for that single cycle.
- Ack and timeout in the same cycle: ack wins and there is no error pulse.
- Set and clear of the same pending bit in the same cycle (new rise during its GRANT): set wins, and the bit stays 1.
- Reset mid-operation: everything returns to reset values on the next edge. Pending requests are discarded, and any strobe in flight is dropped.
- A button held high through reset produces exactly one new request after reset deasserts, because prev resets to 0.

## Test plan
Bench parameters: COOLDOWN=4, TIMEOUT=8; `accion_ack` driven 2 cycles after each strobe unless stated otherwise.

- Single press of Boton_Comida at E0 → `accion_valida`=1 with `accion_id`=0 in the cycle after E3. `ocupado` stays high until 4 cycles after the ack. `pendientes` returns to 0.
- All four buttons rise in the same cycle → four strobes with ids 0,1,2,3 in that order, each separated by ack + 4 cooldown cycles. rr ends at 0.
- Boton_Dormir pressed, then Boton_Comida pressed during its WAIT_ACK → id 3 is granted, then id 0 (rr wrapped to 0).
- No ack ever → `error_timeout` pulses exactly 8 cycles after GRANT. The FSM goes to COOLDOWN, then IDLE, and the next pending request proceeds normally.
- Ack held high during GRANT only → ack is ignored and the timeout fires. Ack arriving on the same cycle as the timeout (cycle 8) → no `error_timeout`.
- Reset asserted for 1 cycle during WAIT_ACK with 2 pending bits → all outputs are 0 next cycle and no strobes follow. A button held high through reset yields exactly one new grant afterwards.
